bike_mode_ctrl: RTL and testbench

Display-mode and trip-command controller for the bicycle computer. It debounces the single handlebar button and sequences the display through four modes: speed, distance, trip time and average speed. A long press issues a trip-clear pulse to the trip accumulators (trip time, distance), but only while the bike is stationary. It sits between the button pad and the display mux / trip datapath, and runs on the 2.048 kHz system clock with the shared 1 s tick.

---
 rtl/bike_pkg.sv | 18 +
 rtl/btn_debounce.sv | 61 ++++++
 rtl/bike_mode_ctrl.sv | 95 +++++++++
 tb/tb_bike_mode_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// Shared bicycle-computer definitions: display mode encoding and the trip-clear speed limit.
package bike_pkg;

  typedef enum logic [1:0] {
    MODE_SPD  = 2'd0,
    MODE_DIST = 2'd1,
    MODE_TIME = 2'd2,
    MODE_AVG  = 2'd3
  } mode_e;

  localparam int unsigned STOP_KMH = 5;

  // Display modes cycle in encoding order and wrap from AVG back to SPD.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability-count debouncer for the handlebar button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 41
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_raw_i,
  output logic btn_a_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic            sync1_q, sync2_q;
  logic            btn_a_q, btn_a_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Edge pulses are registered alongside btn_a, so they are high in the cycle btn_a first shows
  // the new level.
  always_comb begin
    btn_a_d   = btn_a_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != btn_a_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        btn_a_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      btn_a_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_raw_i;
      sync2_q   <= sync1_q;
      btn_a_q   <= btn_a_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_a_o   = btn_a_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/bike_mode_ctrl.sv
// Display-mode sequencer and trip-clear controller driven by a single debounced button.
module bike_mode_ctrl
  import bike_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 41,
  parameter int unsigned LONG_S       = 3,
  parameter int unsigned IDLE_S       = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_raw_i,
  input  logic       tick_1s_i,
  input  logic [6:0] kmh_i,
  output mode_e      mode_o,
  output logic       mode_chg_o,
  output logic       trip_clr_o
);

  localparam int unsigned HoldW = $clog2(LONG_S + 1);
  localparam int unsigned IdleW = $clog2(IDLE_S + 1);

  logic             btn_a, press, rel;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             long_done_q, long_done_d;
  logic             trip_clr_q, trip_clr_d;
  logic             mode_chg_q, mode_chg_d;
  mode_e            mode_q, mode_d;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .btn_raw_i(btn_raw_i),
    .btn_a_o  (btn_a),
    .press_o  (press),
    .release_o(rel)
  );

  always_comb begin
    hold_d      = hold_q;
    long_done_d = long_done_q;
    trip_clr_d  = 1'b0;
    idle_d      = idle_q;
    mode_d      = mode_q;

    // A press in the same cycle as a tick restarts the hold count and swallows the tick.
    if (press) begin
      hold_d      = '0;
      long_done_d = 1'b0;
    end else if (tick_1s_i && btn_a && hold_q != HoldW'(LONG_S)) begin
      hold_d = hold_q + 1'b1;
      if (hold_q == HoldW'(LONG_S - 1)) begin
        long_done_d = 1'b1;
        trip_clr_d  = kmh_i < 7'(STOP_KMH);
      end
    end

    if (press || rel || mode_q == MODE_SPD) begin
      idle_d = '0;
    end else if (tick_1s_i && !btn_a && idle_q != IdleW'(IDLE_S)) begin
      idle_d = idle_q + 1'b1;
      if (idle_q == IdleW'(IDLE_S - 1)) mode_d = MODE_SPD;
    end

    // Short-press release takes priority over an idle timeout in the same cycle.
    if (rel && !long_done_q) mode_d = next_mode(mode_q);

    mode_chg_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q      <= '0;
      idle_q      <= '0;
      long_done_q <= 1'b0;
      trip_clr_q  <= 1'b0;
      mode_chg_q  <= 1'b0;
      mode_q      <= MODE_SPD;
    end else begin
      hold_q      <= hold_d;
      idle_q      <= idle_d;
      long_done_q <= long_done_d;
      trip_clr_q  <= trip_clr_d;
      mode_chg_q  <= mode_chg_d;
      mode_q      <= mode_d;
    end
  end

  assign mode_o     = mode_q;
  assign mode_chg_o = mode_chg_q;
  assign trip_clr_o = trip_clr_q;

endmodule

// File: tb/tb_bike_mode_ctrl.sv
// Scenario bench for bike_mode_ctrl with randomized timing against an event-level mode model.
module tb_bike_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic       tick_1s;
  logic [6:0] kmh;
  logic [1:0] mode;
  logic       mode_chg;
  logic       trip_clr;

  int checks = 0;
  int errors = 0;
  int n_chg  = 0;
  int n_clr  = 0;
  int model_mode = 0;

  // Raw edge just after edge 0 -> mode visible just after edge DEB + 3.
  localparam int ModeLat = 44;
  localparam int StopKmh = 5;

  always #5 clk = ~clk;

  bike_mode_ctrl dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .btn_raw_i (btn_raw),
    .tick_1s_i (tick_1s),
    .kmh_i     (kmh),
    .mode_o    (mode),
    .mode_chg_o(mode_chg),
    .trip_clr_o(trip_clr)
  );

  always @(negedge clk) begin
    if (mode_chg === 1'b1) n_chg++;
    if (trip_clr === 1'b1) n_clr++;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_after(input int gap);
    cycles(gap);
    tick_1s = 1'b1;
    cycles(1);
    tick_1s = 1'b0;
  endtask

  task automatic short_press(input int hold);
    btn_raw = 1'b1;
    cycles(hold);
    btn_raw = 1'b0;
    cycles(100);
    model_mode = (model_mode + 1) % 4;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_raw = 1'b0; tick_1s = 1'b0; kmh = '0;
    #23;
    checks++;
    if (mode !== 2'd0) begin
      errors++; $display("FAIL reset_mode: got %0d expected 0", mode);
    end
    checks++;
    if (mode_chg !== 1'b0) begin
      errors++; $display("FAIL reset_mode_chg: got %0b expected 0", mode_chg);
    end
    checks++;
    if (trip_clr !== 1'b0) begin
      errors++; $display("FAIL reset_trip_clr: got %0b expected 0", trip_clr);
    end
    @(posedge clk); #1;
    cycles(2);
    reset = 1'b0;
    model_mode = 0;
    cycles(5);
  endtask

  task automatic test_clean_presses();
    int c0, t0, hold, gap, exp_mode;
    c0 = n_chg; t0 = n_clr;
    for (int i = 0; i < 4; i++) begin
      hold = int'($urandom_range(100, 140));
      gap  = int'($urandom_range(200, 260));
      kmh  = 7'($urandom_range(0, 99));
      btn_raw = 1'b1;
      cycles(hold);
      btn_raw = 1'b0;
      cycles(ModeLat - 1);
      checks++;
      if (mode !== 2'(model_mode)) begin
        errors++; $display("FAIL clean_pre_adv: got %0d expected %0d", mode, model_mode);
      end
      cycles(1);
      exp_mode = (model_mode + 1) % 4;
      checks++;
      if (mode !== 2'(exp_mode) || mode_chg !== 1'b1) begin
        errors++;
        $display("FAIL clean_adv: got mode %0d chg %0b expected mode %0d chg 1",
                 mode, mode_chg, exp_mode);
      end
      model_mode = exp_mode;
      cycles(gap - ModeLat);
    end
    checks++;
    if (n_chg - c0 != 4) begin
      errors++; $display("FAIL clean_chg_count: got %0d expected 4", n_chg - c0);
    end
    checks++;
    if (n_clr - t0 != 0) begin
      errors++; $display("FAIL clean_no_clr: got %0d expected 0", n_clr - t0);
    end
  endtask

  task automatic test_bounce();
    int c0, exp_mode;
    c0 = n_chg;
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      cycles(int'($urandom_range(2, 8)));
    end
    btn_raw = 1'b0;
    cycles(60);
    short_press(100);
    exp_mode = model_mode;
    checks++;
    if (n_chg - c0 != 1) begin
      errors++; $display("FAIL bounce_chg_count: got %0d expected 1", n_chg - c0);
    end
    checks++;
    if (mode !== 2'(exp_mode)) begin
      errors++; $display("FAIL bounce_mode: got %0d expected %0d", mode, exp_mode);
    end
  endtask

  task automatic test_long_press(input logic [6:0] speed);
    int c0, t0, exp_clr;
    kmh = speed;
    exp_clr = (int'(speed) < StopKmh) ? 1 : 0;
    c0 = n_chg; t0 = n_clr;
    btn_raw = 1'b1;
    cycles(50);
    for (int k = 1; k <= 4; k++) begin
      tick_after(int'($urandom_range(10, 30)));
      if (k == 3) begin
        checks++;
        if (trip_clr !== 1'(exp_clr)) begin
          errors++;
          $display("FAIL long_clr_pulse kmh=%0d: got %0b expected %0d", speed, trip_clr, exp_clr);
        end
        cycles(1);
        checks++;
        if (trip_clr !== 1'b0) begin
          errors++; $display("FAIL long_clr_width kmh=%0d: got %0b expected 0", speed, trip_clr);
        end
        kmh = 7'($urandom_range(0, 99));
      end
    end
    cycles(5);
    checks++;
    if (n_clr - t0 != exp_clr) begin
      errors++;
      $display("FAIL long_clr_count kmh=%0d: got %0d expected %0d", speed, n_clr - t0, exp_clr);
    end
    btn_raw = 1'b0;
    cycles(100);
    checks++;
    if (mode !== 2'(model_mode) || n_chg != c0) begin
      errors++;
      $display("FAIL long_no_adv kmh=%0d: got mode %0d chgs %0d expected mode %0d chgs 0",
               speed, mode, n_chg - c0, model_mode);
    end
  endtask

  task automatic test_idle_return();
    int c0;
    while (model_mode != 2) short_press(int'($urandom_range(60, 120)));
    c0 = n_chg;
    for (int k = 1; k <= 10; k++) begin
      tick_after(int'($urandom_range(5, 20)));
      if (k == 9) begin
        checks++;
        if (mode !== 2'd2) begin
          errors++; $display("FAIL idle_early: got %0d expected 2", mode);
        end
      end
      if (k == 10) begin
        checks++;
        if (mode !== 2'd0 || mode_chg !== 1'b1) begin
          errors++;
          $display("FAIL idle_return: got mode %0d chg %0b expected mode 0 chg 1", mode, mode_chg);
        end
      end
    end
    model_mode = 0;
    cycles(5);
    checks++;
    if (n_chg - c0 != 1) begin
      errors++; $display("FAIL idle_chg_count: got %0d expected 1", n_chg - c0);
    end
  endtask

  task automatic test_release_vs_timeout();
    while (model_mode != 2) short_press(int'($urandom_range(60, 120)));
    for (int k = 1; k <= 9; k++) tick_after(int'($urandom_range(5, 15)));
    btn_raw = 1'b1;
    cycles(int'($urandom_range(60, 90)));
    btn_raw = 1'b0;
    cycles(ModeLat - 1);
    tick_1s = 1'b1;
    cycles(1);
    tick_1s = 1'b0;
    checks++;
    if (mode !== 2'd3 || mode_chg !== 1'b1) begin
      errors++;
      $display("FAIL release_vs_timeout: got mode %0d chg %0b expected mode 3 chg 1",
               mode, mode_chg);
    end
    model_mode = 3;
    cycles(20);
    checks++;
    if (mode !== 2'd3) begin
      errors++; $display("FAIL release_vs_timeout_hold: got %0d expected 3", mode);
    end
  endtask

  task automatic test_reset_mid_hold();
    int c0, t0;
    kmh = 7'($urandom_range(0, StopKmh - 1));
    btn_raw = 1'b1;
    cycles(50);
    tick_after(int'($urandom_range(5, 20)));
    tick_after(int'($urandom_range(5, 20)));
    cycles(7);
    #2;
    reset = 1'b1;
    #1;
    t0 = n_clr;
    checks++;
    if (mode !== 2'd0 || mode_chg !== 1'b0 || trip_clr !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got mode %0d chg %0b clr %0b expected 0 0 0",
               mode, mode_chg, trip_clr);
    end
    @(posedge clk); #1;
    cycles(3);
    reset = 1'b0;
    model_mode = 0;
    c0 = n_chg;
    // Press is accepted on edge 43 after release; a tick in that cycle must be ignored.
    cycles(43);
    tick_1s = 1'b1;
    cycles(2);
    tick_1s = 1'b0;
    tick_after(10);
    checks++;
    if (trip_clr !== 1'b0 || n_clr != t0) begin
      errors++;
      $display("FAIL rst_press_early: got clr %0b pulses %0d expected 0 0", trip_clr, n_clr - t0);
    end
    tick_after(10);
    checks++;
    if (trip_clr !== 1'b1) begin
      errors++; $display("FAIL rst_press_timing: got %0b expected 1", trip_clr);
    end
    btn_raw = 1'b0;
    cycles(100);
    checks++;
    if (mode !== 2'd0 || n_chg != c0) begin
      errors++;
      $display("FAIL rst_after_release: got mode %0d chgs %0d expected 0 0", mode, n_chg - c0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_presses();
    test_bounce();
    test_long_press(7'd0);
    test_long_press(7'd12);
    test_long_press(7'(StopKmh - 1));
    test_long_press(7'(StopKmh));
    test_long_press(7'($urandom_range(0, StopKmh - 1)));
    test_long_press(7'($urandom_range(StopKmh, 99)));
    test_idle_return();
    test_release_vs_timeout();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
